// File: rtl/memory_fetch_responder.sv
// memory_fetch_responder
// Pulls record indices from an address generator, reads WORDS_PER_RECORD
// consecutive memory words per record, assembles up to three of them into
// rec_x/rec_y/rec_z and hands the record to a consumer with a valid/ready
// handshake. Each fetch_data_ready pulse asks the generator for the next index.
module memory_fetch_responder #(
  parameter int WORDS_PER_RECORD = 3,
  parameter int MEM_LATENCY      = 2,
  parameter int SETTLE_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        output_enable,
  input  logic        end_of_memory,
  output logic        fetch_data_ready,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rec_x,
  output logic [31:0] rec_y,
  output logic [31:0] rec_z,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_count,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_PRIME,
    ST_SETTLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_PULSE,
    ST_STOP
  } state_t;

  state_t                 state_reg;
  logic [31:0]            settle_cnt_reg;
  logic [31:0]            issue_cnt_reg;
  logic [31:0]            cap_cnt_reg;
  logic                   eom_seen_reg;
  logic [MEM_LATENCY-1:0] strobe_pipe_reg;
  logic                   capture;
  logic                   last_word;

  // A strobe issued in cycle t has its data on mem_rdata in cycle t+MEM_LATENCY,
  // which is exactly when the strobe reaches the end of this delay line.
  assign capture   = strobe_pipe_reg[MEM_LATENCY-1];
  assign last_word = (cap_cnt_reg == 32'(WORDS_PER_RECORD - 1));

  generate
    for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_strobe_pipe
      // Delay the read strobe by one stage; reset drops any read in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          strobe_pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          strobe_pipe_reg[gi] <= mem_rd_en;
        end else begin
          strobe_pipe_reg[gi] <= strobe_pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // Fetch sequencer: state, registered outputs and record assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_PRIME;
      settle_cnt_reg   <= 32'd0;
      issue_cnt_reg    <= 32'd0;
      cap_cnt_reg      <= 32'd0;
      eom_seen_reg     <= 1'b0;
      fetch_data_ready <= 1'b0;
      mem_rd_en        <= 1'b0;
      mem_addr         <= 32'd0;
      rec_x            <= 32'd0;
      rec_y            <= 32'd0;
      rec_z            <= 32'd0;
      rec_valid        <= 1'b0;
      rec_count        <= 32'd0;
      done             <= 1'b0;
    end else begin
      // Remember an end_of_memory seen while a record is in progress so the
      // record still finishes but no further index is requested.
      if ((state_reg == ST_ISSUE || state_reg == ST_WAIT || state_reg == ST_HOLD)
          && end_of_memory) begin
        eom_seen_reg <= 1'b1;
      end

      case (state_reg)
        ST_PRIME: begin
          fetch_data_ready <= 1'b1;
          settle_cnt_reg   <= 32'd0;
          state_reg        <= ST_SETTLE;
        end

        ST_SETTLE: begin
          // The first SETTLE cycle carries the request pulse; count the
          // following low cycles before looking at the generator.
          fetch_data_ready <= 1'b0;
          if (settle_cnt_reg < 32'(SETTLE_CYCLES)) begin
            settle_cnt_reg <= settle_cnt_reg + 32'd1;
          end else if (end_of_memory) begin
            done      <= 1'b1;
            state_reg <= ST_STOP;
          end else if (output_enable) begin
            mem_rd_en     <= 1'b1;
            mem_addr      <= address * 32'(WORDS_PER_RECORD);
            issue_cnt_reg <= 32'd1;
            cap_cnt_reg   <= 32'd0;
            eom_seen_reg  <= 1'b0;
            state_reg     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (issue_cnt_reg >= 32'(WORDS_PER_RECORD)) begin
            mem_rd_en <= 1'b0;
            state_reg <= ST_WAIT;
          end else begin
            mem_addr      <= mem_addr + 32'd1;
            issue_cnt_reg <= issue_cnt_reg + 32'd1;
          end
        end

        ST_WAIT: begin
          if (capture && last_word) begin
            rec_valid <= 1'b1;
            state_reg <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            rec_count <= rec_count + 32'd1;
            if (eom_seen_reg || end_of_memory) begin
              done      <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              state_reg <= ST_PULSE;
            end
          end
        end

        ST_PULSE: begin
          fetch_data_ready <= 1'b1;
          settle_cnt_reg   <= 32'd0;
          state_reg        <= ST_SETTLE;
        end

        ST_STOP: begin
          done             <= 1'b1;
          fetch_data_ready <= 1'b0;
          mem_rd_en        <= 1'b0;
        end

        default: begin
          state_reg <= ST_PRIME;
        end
      endcase

      // Steer returning words into slots 0..2; anything past slot 2 is dropped.
      if (capture && (state_reg == ST_ISSUE || state_reg == ST_WAIT)) begin
        if (cap_cnt_reg == 32'd0) rec_x <= mem_rdata;
        if (cap_cnt_reg == 32'd1) rec_y <= mem_rdata;
        if (cap_cnt_reg == 32'd2) rec_z <= mem_rdata;
        cap_cnt_reg <= last_word ? 32'd0 : cap_cnt_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_fetch_responder.sv
// Directed bench for memory_fetch_responder (WORDS_PER_RECORD=3,
// MEM_LATENCY=3, SETTLE_CYCLES=2). Memory word i holds (i+1)*16.
module tb_memory_fetch_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'd0;
  logic        output_enable = 1'b0;
  logic        end_of_memory = 1'b0;
  logic        fetch_data_ready;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] rec_x, rec_y, rec_z;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [31:0] rec_count;
  logic        done;

  memory_fetch_responder #(
    .WORDS_PER_RECORD(3),
    .MEM_LATENCY(LAT),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .output_enable(output_enable),
    .end_of_memory(end_of_memory),
    .fetch_data_ready(fetch_data_ready),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .rec_x(rec_x),
    .rec_y(rec_y),
    .rec_z(rec_z),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_count(rec_count),
    .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: fixed-latency read pipe
  logic [31:0] mem [0:15];
  logic [31:0] rd_pipe [0:LAT-1];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_rd_en && mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Monitor: pulse counting, pulse width, gaps, read log, transfers
  int          pulses = 0;
  int          hi_samples = 0;
  int          low_run = 0;
  int          min_gap = 1000000;
  bit          seen_pulse = 1'b0;
  logic        fdr_prev = 1'b0;
  int          rd_n = 0;
  int          bad_rd = 0;
  logic [31:0] rd_log [0:63];

  always @(negedge clk) begin
    if (fetch_data_ready) begin
      hi_samples++;
      if (!fdr_prev) begin
        pulses++;
        if (seen_pulse && low_run < min_gap) min_gap = low_run;
        seen_pulse = 1'b1;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    fdr_prev = fetch_data_ready;
    if (mem_rd_en) begin
      rd_log[rd_n % 64] = mem_addr;
      rd_n++;
      if (done) bad_rd++;
    end
    if (rec_valid && rec_ready)
      $display("record %0d x=%h y=%h z=%h", rec_count, rec_x, rec_y, rec_z);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // which: 0 = rec_valid, 1 = mem_rd_en; waits until it equals lvl
  task automatic wait_for(input int which, input logic lvl, input string tag);
    int n;
    logic s;
    n = 0;
    s = (which == 0) ? rec_valid : mem_rd_en;
    while (s !== lvl && n < 200) begin
      step();
      n++;
      s = (which == 0) ? rec_valid : mem_rd_en;
    end
    check(tag, {31'd0, s}, {31'd0, lvl});
  endtask

  int base_p;
  int base_rd;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'((i + 1) * 16);

    // Reset state
    steps(3);
    check("rst_fdr", {31'd0, fetch_data_ready}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_valid", {31'd0, rec_valid}, 32'd0);
    check("rst_count", rec_count, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Prime pulse with output_enable low, then idle in SETTLE
    rst = 1'b1;
    step();
    check("prime_hi", {31'd0, fetch_data_ready}, 32'd1);
    step();
    check("prime_lo", {31'd0, fetch_data_ready}, 32'd0);
    steps(10);
    check("prime_pulses", pulses, 32'd1);
    check("idle_no_read", rd_n, 32'd0);

    // Record at address 0, consumer always ready
    base_p = pulses; base_rd = rd_n;
    address = 32'd0; output_enable = 1'b1; rec_ready = 1'b1;
    wait_for(0, 1'b1, "r0_valid_to");
    output_enable = 1'b0;
    check("r0_x", rec_x, 32'h10);
    check("r0_y", rec_y, 32'h20);
    check("r0_z", rec_z, 32'h30);
    steps(12);
    check("r0_count", rec_count, 32'd1);
    check("r0_pulse", pulses - base_p, 32'd1);
    check("r0_nreads", rd_n - base_rd, 32'd3);
    check("r0_a0", rd_log[base_rd % 64], 32'd0);
    check("r0_a1", rd_log[(base_rd + 1) % 64], 32'd1);
    check("r0_a2", rd_log[(base_rd + 2) % 64], 32'd2);

    // Record at address 4, consumer stalls 5 cycles
    base_p = pulses; base_rd = rd_n;
    address = 32'd4; output_enable = 1'b1; rec_ready = 1'b0;
    wait_for(0, 1'b1, "r1_valid_to");
    output_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("r1_hold_valid", {31'd0, rec_valid}, 32'd1);
      check("r1_hold_x", rec_x, 32'hD0);
      check("r1_hold_z", rec_z, 32'hF0);
      step();
    end
    check("r1_no_pulse", pulses - base_p, 32'd0);
    check("r1_y", rec_y, 32'hE0);
    rec_ready = 1'b1;
    step();
    check("r1_valid_fall", {31'd0, rec_valid}, 32'd0);
    check("r1_count", rec_count, 32'd2);
    steps(8);
    check("r1_pulse", pulses - base_p, 32'd1);
    check("r1_a0", rd_log[base_rd % 64], 32'd12);
    check("r1_a1", rd_log[(base_rd + 1) % 64], 32'd13);
    check("r1_a2", rd_log[(base_rd + 2) % 64], 32'd14);

    // end_of_memory raised during WAIT
    base_p = pulses;
    address = 32'd1; output_enable = 1'b1;
    wait_for(1, 1'b1, "eom_rd_hi_to");
    wait_for(1, 1'b0, "eom_rd_lo_to");
    end_of_memory = 1'b1; output_enable = 1'b0;
    wait_for(0, 1'b1, "eom_valid_to");
    check("eom_x", rec_x, 32'h40);
    check("eom_z", rec_z, 32'h60);
    steps(15);
    check("eom_count", rec_count, 32'd3);
    check("eom_no_pulse", pulses - base_p, 32'd0);
    check("eom_done", {31'd0, done}, 32'd1);
    check("eom_rd_en", {31'd0, mem_rd_en}, 32'd0);
    end_of_memory = 1'b0; output_enable = 1'b1;
    steps(10);
    check("stop_sticky", {31'd0, done}, 32'd1);

    // Asynchronous reset out of STOP
    rst = 1'b0;
    #1;
    check("arst_count", rec_count, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);

    // Reset mid-WAIT with reads in flight
    step();
    address = 32'd2; output_enable = 1'b1;
    rst = 1'b1;
    wait_for(1, 1'b1, "mw_rd_hi_to");
    wait_for(1, 1'b0, "mw_rd_lo_to");
    rst = 1'b0;
    output_enable = 1'b0;
    #1;
    check("mw_fdr", {31'd0, fetch_data_ready}, 32'd0);
    check("mw_addr", mem_addr, 32'd0);
    check("mw_valid", {31'd0, rec_valid}, 32'd0);
    check("mw_x", rec_x, 32'd0);
    steps(5);
    base_rd = rd_n;
    rst = 1'b1;
    step();
    check("mw_prime", {31'd0, fetch_data_ready}, 32'd1);
    steps(10);
    check("mw_late_x", rec_x, 32'd0);
    check("mw_late_valid", {31'd0, rec_valid}, 32'd0);
    check("mw_late_count", rec_count, 32'd0);
    check("mw_no_read", rd_n - base_rd, 32'd0);

    // Back-to-back addresses 0..4 driven by a generator model
    rst = 1'b0;
    steps(2);
    base_p = pulses;
    address = 32'd0; end_of_memory = 1'b0; output_enable = 1'b1; rec_ready = 1'b1;
    rst = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      step();
      if (pulses - base_p >= 1) address = 32'(pulses - base_p - 1);
      if (pulses - base_p >= 6) end_of_memory = 1'b1;
    end
    check("b2b_done", {31'd0, done}, 32'd1);
    steps(10);
    check("b2b_count", rec_count, 32'd5);
    check("b2b_pulses", pulses - base_p, 32'd6);
    check("b2b_last_z", rec_z, 32'hF0);
    check("pulse_width", hi_samples, pulses);
    check("min_gap_ok", {31'd0, (min_gap >= 3)}, 32'd1);
    check("no_rd_when_done", bad_rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
